// File: rtl/video_pattern_gen_if.sv
// Pixel stream bundle (vsync, data enable, packed RGB data) between a video
// source and its downstream window-tap consumers.
interface video_pattern_gen_if #(
    parameter int unsigned DSIZE = 24
) ();
    logic             outvs;
    logic             outde;
    logic [DSIZE-1:0] outdata;

    modport master (
        output outvs,
        output outde,
        output outdata
    );

    modport slave (
        input outvs,
        input outde,
        input outdata
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Frame-timing video source: blanking-first H/V counters driving a vs/de/data
// stream filled with a ramp, colour-bar, checker or solid test pattern.
module video_pattern_gen #(
    parameter int unsigned DSIZE            = 24,
    parameter int unsigned VIDEO_WIDTH      = 1920,
    parameter int unsigned VIDEO_PRE_WIDTH  = 280,
    parameter int unsigned VIDEO_HEIGHT     = 1080,
    parameter int unsigned VIDEO_PRE_HEIGHT = 45,
    parameter int unsigned VS_LINES         = 5,
    parameter int unsigned CHECK_LOG2       = 6
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           pattern,
    video_pattern_gen_if.master  vid,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);

    localparam int unsigned C       = DSIZE / 3;
    localparam int unsigned H_TOTAL = VIDEO_WIDTH + VIDEO_PRE_WIDTH;
    localparam int unsigned V_TOTAL = VIDEO_HEIGHT + VIDEO_PRE_HEIGHT;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned SEG     = VIDEO_WIDTH / 8;
    localparam int unsigned SW      = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int unsigned XYW0    = (HW > VW) ? HW : VW;
    localparam int unsigned XYW     = (XYW0 > CHECK_LOG2 + 1) ? XYW0 : CHECK_LOG2 + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] PAT_RAMP    = 2'd0;
    localparam logic [1:0] PAT_BARS    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_SOLID   = 2'd3;

    localparam logic [C-1:0] CH_MAX = {C{1'b1}};

    logic [0:0]    state, state_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [VW-1:0] vcnt, vcnt_nxt;
    logic [7:0]    frame_nxt;
    logic [1:0]    pat_q, pat_nxt;
    logic [SW-1:0] seg_cnt, seg_nxt;
    logic [2:0]    bar_idx, bar_nxt;

    logic             vs_q, de_q;
    logic [DSIZE-1:0] data_q;

    logic             line_end_c, frame_end_c, h_active_c;
    logic             vs_c, de_c, chk_c;
    logic [C-1:0]     ramp_c;
    logic [2:0]       bar_inv_c;
    logic [DSIZE-1:0] pix_c;

    // Counter decode
    assign line_end_c  = (hcnt == HW'(H_TOTAL - 1));
    assign frame_end_c = line_end_c && (vcnt == VW'(V_TOTAL - 1));
    assign h_active_c  = (hcnt >= HW'(VIDEO_PRE_WIDTH));
    assign vs_c        = (vcnt < VW'(VS_LINES));
    assign de_c        = (vcnt >= VW'(VIDEO_PRE_HEIGHT)) && h_active_c;

    // Pattern sources; x/y only matter while de_c is high
    assign ramp_c    = C'(XYW'(hcnt) - XYW'(VIDEO_PRE_WIDTH));
    assign chk_c     = 1'(((XYW'(hcnt) - XYW'(VIDEO_PRE_WIDTH)) ^
                           (XYW'(vcnt) - XYW'(VIDEO_PRE_HEIGHT))) >> CHECK_LOG2);
    assign bar_inv_c = ~bar_idx;

    always_comb begin
        pix_c = '0;
        if (de_c) begin
            case (pat_q)
                PAT_RAMP:    pix_c = {ramp_c, ramp_c, ramp_c};
                PAT_BARS:    pix_c = {bar_inv_c[2] ? CH_MAX : C'(0),
                                      bar_inv_c[1] ? CH_MAX : C'(0),
                                      bar_inv_c[0] ? CH_MAX : C'(0)};
                PAT_CHECKER: pix_c = chk_c ? {3{CH_MAX}} : '0;
                PAT_SOLID:   pix_c = {3{C'(frame_cnt)}};
                default:     pix_c = '0;
            endcase
        end
    end

    // Next-state: frame sequencing, counters, bar segment tracking
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        vcnt_nxt  = vcnt;
        frame_nxt = frame_cnt;
        pat_nxt   = pat_q;
        seg_nxt   = seg_cnt;
        bar_nxt   = bar_idx;

        case (state)
            ST_IDLE: begin
                hcnt_nxt = '0;
                vcnt_nxt = '0;
                seg_nxt  = '0;
                bar_nxt  = '0;
                if (enable) begin
                    state_nxt = ST_RUN;
                    pat_nxt   = pattern;
                end
            end
            ST_RUN: begin
                if (line_end_c) begin
                    hcnt_nxt = '0;
                    seg_nxt  = '0;
                    bar_nxt  = '0;
                    if (frame_end_c) begin
                        vcnt_nxt  = '0;
                        frame_nxt = frame_cnt + 8'd1;
                        if (enable) begin
                            pat_nxt = pattern;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        vcnt_nxt = vcnt + VW'(1);
                    end
                end else begin
                    hcnt_nxt = hcnt + HW'(1);
                    // Bars advance every SEG active pixels, avoiding a divider
                    if (h_active_c) begin
                        if (seg_cnt == SW'(SEG - 1)) begin
                            seg_nxt = '0;
                            bar_nxt = bar_idx + 3'd1;
                        end else begin
                            seg_nxt = seg_cnt + SW'(1);
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
            pat_q     <= '0;
            seg_cnt   <= '0;
            bar_idx   <= '0;
        end else begin
            state     <= state_nxt;
            hcnt      <= hcnt_nxt;
            vcnt      <= vcnt_nxt;
            frame_cnt <= frame_nxt;
            pat_q     <= pat_nxt;
            seg_cnt   <= seg_nxt;
            bar_idx   <= bar_nxt;
        end
    end

    // Stream outputs lag the counters by one cycle; the last pixel of a frame
    // is still emitted in the first IDLE cycle
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            data_q <= '0;
        end else if (state == ST_RUN) begin
            vs_q   <= vs_c;
            de_q   <= de_c;
            data_q <= pix_c;
        end else begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            data_q <= '0;
        end
    end

    assign vid.outvs   = vs_q;
    assign vid.outde   = de_q;
    assign vid.outdata = data_q;
    assign busy        = (state == ST_RUN);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: per-frame expected streams are queued
// from a reference model and compared pixel by pixel against the DUT.
module tb_video_pattern_gen;

    localparam int unsigned DSIZE = 24;
    localparam int W     = 16;
    localparam int PW    = 4;
    localparam int H     = 8;
    localparam int PH    = 3;
    localparam int VSL   = 1;
    localparam int CL    = 2;
    localparam int HT    = W + PW;
    localparam int VT    = H + PH;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        vs;
        logic        de;
        logic [23:0] data;
    } pix_t;

    logic       clock;
    logic       rst_n;
    logic       enable;
    logic [1:0] pattern;
    logic       busy;
    logic [7:0] frame_cnt;

    int   checks;
    int   errors;
    pix_t sb[$];
    int   vs_seen, de_seen, first_vs, first_de;

    video_pattern_gen_if #(.DSIZE(DSIZE)) vid ();

    video_pattern_gen #(
        .DSIZE(DSIZE), .VIDEO_WIDTH(W), .VIDEO_PRE_WIDTH(PW),
        .VIDEO_HEIGHT(H), .VIDEO_PRE_HEIGHT(PH), .VS_LINES(VSL), .CHECK_LOG2(CL)
    ) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .pattern(pattern),
        .vid(vid), .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] exp_pix(input logic [1:0] pat, input int x, input int y,
                                            input logic [7:0] fc);
        logic [7:0] c;
        logic [2:0] bp;
        case (pat)
            2'd0: begin c = 8'(x); return {c, c, c}; end
            2'd1: begin
                bp = 3'(7 - x / (W / 8));
                return {{8{bp[2]}}, {8{bp[1]}}, {8{bp[0]}}};
            end
            2'd2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            default: return {fc, fc, fc};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue one frame of expectations, then compare n output cycles.
    // At cycle chg_at the next pattern/enable are driven (mid-frame change).
    task automatic run_frame(input logic [1:0] pat, input logic [7:0] fc, input int n,
                             input int chg_at, input logic [1:0] new_pat, input logic new_en);
        pix_t e, o;
        for (int i = 0; i < FRAME; i++) begin
            int h, v;
            h      = i % HT;
            v      = i / HT;
            e.vs   = (v < VSL);
            e.de   = (v >= PH) && (h >= PW);
            e.data = e.de ? exp_pix(pat, h - PW, v - PH, fc) : 24'h0;
            sb.push_back(e);
        end
        vs_seen = 0; de_seen = 0; first_vs = -1; first_de = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i == chg_at) begin
                pattern = new_pat;
                enable  = new_en;
            end
            o = {vid.outvs, vid.outde, vid.outdata};
            if (o.vs) begin vs_seen++; if (first_vs < 0) first_vs = i; end
            if (o.de) begin de_seen++; if (first_de < 0) first_de = i; end
            e = sb.pop_front();
            check($sformatf("pix pat%0d fc%0d i%0d", pat, fc, i), 64'(o), 64'(e));
        end
        sb.delete();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        pattern = 2'd0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_stream", 64'({vid.outvs, vid.outde, vid.outdata}), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_frame_cnt", 64'(frame_cnt), 64'(0));
        rst_n = 1'b1;
        @(negedge clock);
        check("idle_busy", 64'(busy), 64'(0));
        enable  = 1'b1;
        pattern = 2'd0;

        // First edge: RUN entered, vsync not yet visible
        @(negedge clock);
        check("start_busy", 64'(busy), 64'(1));
        check("start_vs_low", 64'(vid.outvs), 64'(0));

        // Frame 0: ramp + timing; pattern change mid-frame is deferred
        run_frame(2'd0, 8'd0, FRAME, 5, 2'd2, 1'b1);
        check("t_first_vs", 64'(first_vs), 64'(0));
        check("t_vs_cycles", 64'(vs_seen), 64'(20));
        check("t_de_cycles", 64'(de_seen), 64'(128));
        check("t_vs_to_de", 64'(first_de - first_vs), 64'(64));
        check("t_frame_cnt1", 64'(frame_cnt), 64'(1));

        // Frame 1: checker; switch to solid and drop enable mid-frame
        run_frame(2'd2, 8'd1, FRAME, 100, 2'd3, 1'b0);
        check("drop_busy", 64'(busy), 64'(0));
        check("drop_frame_cnt", 64'(frame_cnt), 64'(2));
        @(negedge clock);
        check("drop_stream_zero", 64'({vid.outvs, vid.outde, vid.outdata}), 64'(0));
        check("drop_busy_hold", 64'(busy), 64'(0));
        repeat (3) @(negedge clock);
        check("idle_stream_zero", 64'({vid.outvs, vid.outde, vid.outdata}), 64'(0));
        enable  = 1'b1;
        pattern = 2'd3;
        @(negedge clock);
        check("restart_busy", 64'(busy), 64'(1));
        check("restart_vs_low", 64'(vid.outvs), 64'(0));

        // Frame 2: solid 0x020202; queue bars for the next frame
        run_frame(2'd3, 8'd2, FRAME, 50, 2'd1, 1'b1);
        check("frame_cnt3", 64'(frame_cnt), 64'(3));

        // Frame 3: bars, interrupted by reset during an active line
        run_frame(2'd1, 8'd3, 100, -1, 2'd1, 1'b1);
        check("pre_reset_de", 64'(vid.outde), 64'(1));
        #2;
        rst_n   = 1'b0;
        enable  = 1'b0;
        pattern = 2'd0;
        #1;
        check("async_stream_zero", 64'({vid.outvs, vid.outde, vid.outdata}), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_frame_cnt", 64'(frame_cnt), 64'(0));
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        check("rr_busy", 64'(busy), 64'(1));
        check("rr_vs_first_edge", 64'(vid.outvs), 64'(0));

        // Fresh frame from (0,0) after reset; drop enable so it ends in IDLE
        run_frame(2'd0, 8'd0, FRAME, 10, 2'd0, 1'b0);
        check("rr_first_vs", 64'(first_vs), 64'(0));
        @(negedge clock);
        check("end_stream_zero", 64'({vid.outvs, vid.outde, vid.outdata}), 64'(0));
        check("end_busy", 64'(busy), 64'(0));
        check("end_frame_cnt", 64'(frame_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Video stream source that drives the vs/de/data pixel interface consumed by the window-tap blocks (array_tap, array_3x3).
- Generates frame timing from horizontal and vertical counters. Horizontal and vertical blanking come before the active region.
- Fills the active region with one of four selectable test patterns.
- Used as the stimulus and bring-up source for the shift-tap pipeline, and as an on-chip test-pattern path.

Parameters:
- DSIZE, 24: pixel width. Must be a multiple of 3; channel width C = DSIZE/3, packed {R,G,B} with R in the MSBs.
- VIDEO_WIDTH, 1920: active pixels per line. Must be divisible by 8.
- VIDEO_PRE_WIDTH, 280: horizontal blanking pixels at the start of each line.
- VIDEO_HEIGHT, 1080: active lines per frame.
- VIDEO_PRE_HEIGHT, 45: vertical blanking lines at the start of each frame.
- VS_LINES, 5: number of lines outvs is high, starting at line 0. Requires 1 <= VS_LINES <= VIDEO_PRE_HEIGHT.
- CHECK_LOG2, 6: checker square size is 2^CHECK_LOG2 pixels.

Ports:
- clock, input, 1: single clock for the whole block.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: request to run. Sampled only in IDLE and at the end of each frame.
- pattern, input, 2: pattern select. Latched at the start of each frame.
- outvs, output, 1: vertical sync, active high.
- outde, output, 1: data enable, high for active pixels.
- outdata, output, DSIZE: pixel data. Zero whenever outde = 0.
- busy, output, 1: high while the state machine is in RUN.
- frame_cnt, output, 8: number of completed frames, wraps at 255.

Interface: one clock (clock); reset (rst_n) is asynchronous and active-low.

Behaviour:
- Definitions:
  - H_TOTAL = VIDEO_WIDTH + VIDEO_PRE_WIDTH.
  - V_TOTAL = VIDEO_HEIGHT + VIDEO_PRE_HEIGHT.
  - hcnt counts 0..H_TOTAL-1; vcnt counts 0..V_TOTAL-1.
- Reset: state = IDLE, hcnt = vcnt = 0, frame_cnt = 0, latched pattern = 0. outvs, outde, outdata and busy are all 0.
- State machine:
  - IDLE: counters held at 0, outputs 0. If enable = 1 at a clock edge, go to RUN with hcnt = vcnt = 0 and latch pattern.
  - RUN: hcnt increments every cycle. When hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - End of frame (hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1):
    - vcnt wraps to 0 and frame_cnt increments, modulo 256.
    - If enable = 1: stay in RUN and re-latch pattern.
    - If enable = 0: go to IDLE.
    - A frame is therefore never truncated; deasserting enable mid-frame takes effect only at end of frame.
- Timing decode:
  - vs_c = (vcnt < VS_LINES).
  - de_c = (vcnt >= VIDEO_PRE_HEIGHT) and (hcnt >= VIDEO_PRE_WIDTH).
  - Active coordinates: x = hcnt - VIDEO_PRE_WIDTH, y = vcnt - VIDEO_PRE_HEIGHT.
- Output registering and latency:
  - All outputs are registered, one cycle behind the counters.
  - outvs first rises on the 2nd rising edge after enable is sampled high in IDLE.
  - busy follows state with no extra delay.
  - In the cycle after RUN returns to IDLE, outvs, outde and outdata are 0.
- Patterns (MAX = all-ones C-bit value); all are defined only while de_c = 1, and outdata = 0 otherwise:
  - 0, ramp: each channel = x[C-1:0]. Use a zero-extended x when C exceeds the width of x.
  - 1, bars: bar index b = x / (VIDEO_WIDTH/8), built with a segment counter, not a divider.
    - b' = 7 - b.
    - R = MAX if b'[2], else 0; G = MAX if b'[1], else 0; B = MAX if b'[0], else 0.
    - Bar 0 is white, bar 7 is black.
  - 2, checker: all channels = MAX if x[CHECK_LOG2] ^ y[CHECK_LOG2], else 0.
  - 3, solid: all channels = frame_cnt, zero-extended or truncated to C bits. Uses the value held during the frame.
- Other rules:
  - A pattern change mid-frame is ignored until the next frame start.
  - Asynchronous reset mid-frame forces all outputs to 0 immediately and returns to IDLE. The next enable starts a fresh frame at (0,0).

Test Plan:
All scenarios use DSIZE=24, VIDEO_WIDTH=16, VIDEO_PRE_WIDTH=4, VIDEO_HEIGHT=8, VIDEO_PRE_HEIGHT=3, VS_LINES=1, CHECK_LOG2=2. This gives H_TOTAL=20, V_TOTAL=11 and a 220-cycle frame.
- Timing: enable=1 held, pattern=0 -> per frame, outvs high for 20 consecutive cycles; outde high in 8 bursts of 16 cycles (128 cycles total); the first outde comes 64 cycles after outvs rises; frame period 220 cycles; frame_cnt = 1 after the first frame.
- Ramp: pattern=0 -> outdata within each active line is 0x000000, 0x010101, ..., 0x0F0F0F; outdata = 0 whenever outde = 0.
- Bars: pattern=1 -> outdata changes every 2 pixels: FFFFFF, FFFF00, FF00FF, FF0000, 00FFFF, 00FF00, 0000FF, 000000.
- Checker: pattern=2 -> active line y=0 reads 0 x4, FFFFFF x4, 0 x4, FFFFFF x4; line y=4 is the inverse.
- Enable drop and pattern change: in frame 2, switch pattern to 3 and drop enable mid-frame -> frame 2 completes in full using the old pattern; then busy=0 and all outputs are 0. Re-enable with pattern=3 -> every pixel of the new frame = 0x020202.
- Reset mid-frame: assert rst_n=0 during an active line -> outde, outvs, outdata and busy drop to 0 asynchronously and frame_cnt = 0. After release and enable, outvs rises on the 2nd edge.
